// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback scoreboard: instruction kinds and the
// per-stage entry that follows an instruction from EX through WB.
package wb_pkg;

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_DIV  = 2'd2;

    typedef struct packed {
        logic       v;
        logic       regwr;
        logic [4:0] rd;
        logic [1:0] kind;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '0;

endpackage

// File: rtl/wb_scoreboard_if.sv
// ID-stage request, flush and forwarding/stall signals exchanged between the pipeline
// and the writeback scoreboard.
interface wb_scoreboard_if;

    logic       id_valid;
    logic       id_regwr;
    logic [4:0] id_rd;
    logic [1:0] id_kind;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       flush;
    logic       stall_id;
    logic       ex_hold;
    logic       ex_mem_regwr;
    logic [4:0] ex_mem_regwraddr;
    logic       mem_wb_regwr;
    logic [4:0] mem_wb_regwraddr;

    modport master (
        output id_valid, id_regwr, id_rd, id_kind, id_rs, id_rt, id_use_rs, id_use_rt, flush,
        input  stall_id, ex_hold, ex_mem_regwr, ex_mem_regwraddr, mem_wb_regwr,
               mem_wb_regwraddr
    );

    modport slave (
        input  id_valid, id_regwr, id_rd, id_kind, id_rs, id_rt, id_use_rs, id_use_rt, flush,
        output stall_id, ex_hold, ex_mem_regwr, ex_mem_regwraddr, mem_wb_regwr,
               mem_wb_regwraddr
    );

endinterface

// File: rtl/div_latency_counter.sv
// Down-counter of remaining EX hold cycles for a divide; zero means the divide may leave EX.
module div_latency_counter #(
    parameter int unsigned DIV_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [3:0] LoadVal = 4'(DIV_LAT - 1);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = LoadVal;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/wb_scoreboard.sv
// Tracks destination registers through EX/MEM/WB, drives the forwarding write pairs and
// raises the ID stall for load-use hazards and divides held in EX.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int unsigned DIV_LAT = 4
) (
    input logic            clk,
    input logic            rst_n,
    wb_scoreboard_if.slave bus
);

    stage_entry_t ex_q, ex_d, mem_q, mem_d, wb_q;
    stage_entry_t id_entry;
    logic         div_zero;
    logic         ex_hold;
    logic         load_use;
    logic         stall;
    logic         div_load;

    always_comb begin
        id_entry       = BUBBLE;
        id_entry.v     = bus.id_valid;
        id_entry.regwr = bus.id_valid & bus.id_regwr & (bus.id_rd != 5'd0);
        id_entry.rd    = bus.id_rd;
        id_entry.kind  = bus.id_kind;
    end

    assign ex_hold = ex_q.v && (ex_q.kind == KIND_DIV) && !div_zero;

    assign load_use = ex_q.v && ex_q.regwr && (ex_q.kind == KIND_LOAD) && (ex_q.rd != 5'd0) &&
                      ((bus.id_use_rs && bus.id_rs == ex_q.rd) ||
                       (bus.id_use_rt && bus.id_rt == ex_q.rd));

    assign stall = bus.id_valid && (load_use || ex_hold) && !bus.flush;

    // EX priority: flush > divide hold > stall bubble > capture from ID
    always_comb begin
        ex_d     = id_entry;
        div_load = 1'b0;
        if (bus.flush) begin
            ex_d = BUBBLE;
        end else if (ex_hold) begin
            ex_d = ex_q;
        end else if (stall) begin
            ex_d = BUBBLE;
        end else begin
            div_load = bus.id_valid && (bus.id_kind == KIND_DIV);
        end
    end

    assign mem_d = ex_hold ? BUBBLE : ex_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= mem_q;
        end
    end

    div_latency_counter #(
        .DIV_LAT(DIV_LAT)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (bus.flush),
        .load (div_load),
        .dec  (ex_hold),
        .zero (div_zero)
    );

    assign bus.stall_id         = stall;
    assign bus.ex_hold          = ex_hold;
    assign bus.ex_mem_regwr     = mem_q.v & mem_q.regwr;
    assign bus.ex_mem_regwraddr = (mem_q.v & mem_q.regwr) ? mem_q.rd : 5'd0;
    assign bus.mem_wb_regwr     = wb_q.v & wb_q.regwr;
    assign bus.mem_wb_regwraddr = (wb_q.v & wb_q.regwr) ? wb_q.rd : 5'd0;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus a queue of expected WB writes that
// is checked whenever the WB stage reports a register write.
module tb_wb_scoreboard;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [4:0] sb_q[$];

    wb_scoreboard_if bus ();

    wb_scoreboard #(
        .DIV_LAT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt);
        bus.id_valid  = v;
        bus.id_regwr  = rw;
        bus.id_rd     = rd;
        bus.id_kind   = kind;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Every WB write must match the oldest expected destination.
    task automatic wb_monitor();
        logic [4:0] exp_rd;
        if (bus.mem_wb_regwr) begin
            check_eq("wb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_rd = sb_q.pop_front();
                check_eq("wb_addr", 32'(bus.mem_wb_regwraddr), 32'(exp_rd));
            end
        end else begin
            check_eq("wb_addr_zero", 32'(bus.mem_wb_regwraddr), 32'd0);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        wb_monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            settle();
            advance();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        settle();
        check_eq("rst_stall", 32'(bus.stall_id), 32'd0);
        check_eq("rst_hold", 32'(bus.ex_hold), 32'd0);
        check_eq("rst_exmem_wr", 32'(bus.ex_mem_regwr), 32'd0);
        check_eq("rst_exmem_addr", 32'(bus.ex_mem_regwraddr), 32'd0);
        check_eq("rst_memwb_wr", 32'(bus.mem_wb_regwr), 32'd0);
        advance();

        // ALU chain: r5 then a reader of r5
        drive(1'b1, 1'b1, 5'd5, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sb_q.push_back(5'd5);
        settle();
        check_eq("alu_stall0", 32'(bus.stall_id), 32'd0);
        advance();
        drive(1'b1, 1'b1, 5'd8, 2'd0, 5'd5, 5'd0, 1'b1, 1'b0);
        sb_q.push_back(5'd8);
        settle();
        check_eq("alu_stall1", 32'(bus.stall_id), 32'd0);
        advance();
        idle();
        settle();
        check_eq("alu_exmem_wr", 32'(bus.ex_mem_regwr), 32'd1);
        check_eq("alu_exmem_addr", 32'(bus.ex_mem_regwraddr), 32'd5);
        advance();
        settle();
        check_eq("alu_memwb_wr", 32'(bus.mem_wb_regwr), 32'd1);
        check_eq("alu_memwb_addr", 32'(bus.mem_wb_regwraddr), 32'd5);
        advance();
        drain(3);

        // Reserved kind behaves as ALU: no stall for a dependent reader
        drive(1'b1, 1'b1, 5'd15, 2'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        sb_q.push_back(5'd15);
        settle();
        advance();
        drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd15, 1'b0, 1'b1);
        settle();
        check_eq("rsv_stall", 32'(bus.stall_id), 32'd0);
        advance();
        drain(3);

        // Load-use on rs: exactly one stall cycle
        drive(1'b1, 1'b1, 5'd7, 2'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        sb_q.push_back(5'd7);
        settle();
        check_eq("lu_stall_ld", 32'(bus.stall_id), 32'd0);
        advance();
        drive(1'b1, 1'b1, 5'd9, 2'd0, 5'd7, 5'd0, 1'b1, 1'b0);
        settle();
        check_eq("lu_stall1", 32'(bus.stall_id), 32'd1);
        advance();
        settle();
        check_eq("lu_stall2", 32'(bus.stall_id), 32'd0);
        check_eq("lu_exmem_addr", 32'(bus.ex_mem_regwraddr), 32'd7);
        sb_q.push_back(5'd9);
        advance();
        idle();
        settle();
        check_eq("lu_memwb_addr", 32'(bus.mem_wb_regwraddr), 32'd7);
        check_eq("lu_bubble", 32'(bus.ex_mem_regwr), 32'd0);
        advance();
        drain(3);

        // Load-use on rt only; rs matches but is unused
        drive(1'b1, 1'b1, 5'd4, 2'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        sb_q.push_back(5'd4);
        settle();
        advance();
        drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd4, 5'd4, 1'b0, 1'b1);
        settle();
        check_eq("lu_rt_stall", 32'(bus.stall_id), 32'd1);
        advance();
        settle();
        check_eq("lu_rt_release", 32'(bus.stall_id), 32'd0);
        advance();
        drain(3);

        // Writes to r0 are never tracked
        drive(1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        settle();
        advance();
        drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        settle();
        check_eq("r0_stall", 32'(bus.stall_id), 32'd0);
        advance();
        idle();
        settle();
        check_eq("r0_exmem_wr", 32'(bus.ex_mem_regwr), 32'd0);
        check_eq("r0_exmem_addr", 32'(bus.ex_mem_regwraddr), 32'd0);
        advance();
        drain(3);

        // Divide r3 with DIV_LAT=4, dependent ALU waits three hold cycles
        drive(1'b1, 1'b1, 5'd3, 2'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        sb_q.push_back(5'd3);
        settle();
        check_eq("div_issue_stall", 32'(bus.stall_id), 32'd0);
        advance();
        drive(1'b1, 1'b1, 5'd10, 2'd0, 5'd3, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("div_hold%0d", i), 32'(bus.ex_hold), 32'd1);
            check_eq($sformatf("div_stall%0d", i), 32'(bus.stall_id), 32'd1);
            check_eq($sformatf("div_mem_bubble%0d", i), 32'(bus.ex_mem_regwr), 32'd0);
            advance();
        end
        settle();
        check_eq("div_hold_end", 32'(bus.ex_hold), 32'd0);
        check_eq("div_stall_end", 32'(bus.stall_id), 32'd0);
        sb_q.push_back(5'd10);
        advance();
        idle();
        settle();
        check_eq("div_exmem_wr", 32'(bus.ex_mem_regwr), 32'd1);
        check_eq("div_exmem_addr", 32'(bus.ex_mem_regwraddr), 32'd3);
        advance();
        drain(4);

        // Flush on the 2nd hold cycle of a divide; older r11/r12 still drain
        drive(1'b1, 1'b1, 5'd11, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sb_q.push_back(5'd11);
        settle();
        advance();
        drive(1'b1, 1'b1, 5'd12, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sb_q.push_back(5'd12);
        settle();
        advance();
        drive(1'b1, 1'b1, 5'd13, 2'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        settle();
        advance();
        idle();
        settle();
        check_eq("fl_hold1", 32'(bus.ex_hold), 32'd1);
        check_eq("fl_exmem_addr", 32'(bus.ex_mem_regwraddr), 32'd12);
        advance();
        drive(1'b1, 1'b1, 5'd14, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        settle();
        check_eq("fl_hold2", 32'(bus.ex_hold), 32'd1);
        check_eq("fl_stall", 32'(bus.stall_id), 32'd0);
        check_eq("fl_memwb_addr", 32'(bus.mem_wb_regwraddr), 32'd12);
        advance();
        bus.flush = 1'b0;
        idle();
        settle();
        check_eq("fl_ex_v", 32'(dut.ex_q.v), 32'd0);
        check_eq("fl_hold_off", 32'(bus.ex_hold), 32'd0);
        check_eq("fl_div_cnt", 32'(dut.u_div.cnt_q), 32'd0);
        check_eq("fl_exmem_wr", 32'(bus.ex_mem_regwr), 32'd0);
        advance();
        drain(4);

        // Reset with all stages full; r22/r23 must never reach WB
        drive(1'b1, 1'b1, 5'd21, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        sb_q.push_back(5'd21);
        settle();
        advance();
        drive(1'b1, 1'b1, 5'd22, 2'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        settle();
        advance();
        drive(1'b1, 1'b1, 5'd23, 2'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        settle();
        advance();
        drive(1'b1, 1'b1, 5'd24, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        settle();
        advance();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd25, 2'd0, 5'd23, 5'd0, 1'b1, 1'b0);
        sb_q.push_back(5'd25);
        settle();
        check_eq("rm_stall", 32'(bus.stall_id), 32'd0);
        check_eq("rm_hold", 32'(bus.ex_hold), 32'd0);
        check_eq("rm_exmem_wr", 32'(bus.ex_mem_regwr), 32'd0);
        check_eq("rm_exmem_addr", 32'(bus.ex_mem_regwraddr), 32'd0);
        check_eq("rm_memwb_wr", 32'(bus.mem_wb_regwr), 32'd0);
        check_eq("rm_memwb_addr", 32'(bus.mem_wb_regwraddr), 32'd0);
        advance();
        idle();
        settle();
        advance();
        settle();
        check_eq("rm_new_addr", 32'(bus.ex_mem_regwraddr), 32'd25);
        advance();
        drain(4);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Producer side of the operand-forwarding interface in the 5-stage LoongArch pipeline.
- Tracks each issued instruction's destination register through the EX, MEM and WB stages.
- Drives the EX/MEM and MEM/WB write-enable/address pairs that the forwarding units compare against.
- Generates the ID stall for load-use hazards and for multi-cycle divides held in EX, and handles flushes.

Parameters:
- DIV_LAT, 4, total EX-stage cycles for a divide (legal range 1..16).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active-low
- id_valid  in  1  ID holds a real instruction
- id_regwr  in  1  ID instruction writes a register
- id_rd  in  5  ID destination register
- id_kind  in  2  0=ALU, 1=LOAD, 2=DIV, 3=reserved (treated as ALU)
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_use_rs  in  1  ID reads rs
- id_use_rt  in  1  ID reads rt
- flush  in  1  kill ID and EX (branch taken or exception)
- stall_id  out  1  hold IF/ID this cycle
- ex_hold  out  1  divide still running in EX
- ex_mem_regwr  out  1  MEM-stage instruction writes a register
- ex_mem_regwraddr  out  5  MEM-stage destination
- mem_wb_regwr  out  1  WB-stage instruction writes a register
- mem_wb_regwraddr  out  5  WB-stage destination

Behaviour:
- State:
  - Three stage entries EX, MEM, WB, each {v, regwr, rd, kind}.
  - Divide down-counter div_cnt, 4 bits.
- Reset (rst_n=0 at a clk edge): all entries invalid, all fields 0, div_cnt=0.
  - All outputs are 0 in the cycle after reset.
- Entry capture:
  - An entry's regwr = id_valid & id_regwr & (id_rd != 0).
  - A write to r0 is never tracked.
- Outputs:
  - ex_mem_regwr = MEM.v & MEM.regwr; ex_mem_regwraddr = MEM.rd, forced to 0 when regwr is 0.
  - mem_wb_* are derived from WB the same way.
- ex_hold (combinational): EX.v & EX.kind==DIV & div_cnt != 0.
- load_use (combinational):
  - EX.v & EX.regwr & EX.kind==LOAD, and
  - (id_use_rs & id_rs==EX.rd) or (id_use_rt & id_rt==EX.rd), with EX.rd != 0.
- stall_id = id_valid & (load_use | ex_hold) & ~flush.
- Each clock edge:
  - WB <= MEM.
  - MEM <= bubble if ex_hold, else EX.
  - EX:
    - if flush: bubble;
    - else if ex_hold: keep EX;
    - else if stall_id: bubble;
    - else: capture the ID entry (v = id_valid).
- Divide counter:
  - When a DIV is captured into EX, div_cnt <= DIV_LAT-1.
  - While ex_hold, div_cnt decrements by 1.
  - When div_cnt reaches 0 the DIV leaves EX on the next edge.
  - DIV_LAT=1 therefore behaves exactly like ALU.
- Divide result forwarding: the result is available at EX end, so an ID consumer after the final hold cycle is not stalled; it forwards from EX/MEM.
- Load-use: exactly one stall cycle; the consumer later forwards from MEM/WB.
- Flush during a divide hold:
  - The divide is killed and div_cnt <= 0.
  - MEM and WB (older instructions) are unaffected.
- Priority for EX update: flush > ex_hold > stall_id > capture.
- The reserved kind is handled exactly as ALU.

Decomposition:
- Shared package wb_pkg:
  - KIND_ALU, KIND_LOAD, KIND_DIV constants.
  - stage_entry_t struct {v, regwr, rd[4:0], kind[1:0]}.
  - BUBBLE constant (all zero).
- One sub-module div_latency_counter (load, dec, zero flag, parameter DIV_LAT).

Test Plan:
- ALU chain: ALU r5, then ALU reading r5 next cycle.
  - Required: stall_id=0.
  - Cycle 2: ex_mem_regwr=1, addr=5.
  - Cycle 3: mem_wb_regwr=1, addr=5.
- Load-use: LOAD r7 followed by ALU id_rs=7.
  - Required: stall_id=1 for exactly one cycle, then EX holds a bubble.
  - Next cycle: stall_id=0; the load reaches WB when the consumer reaches EX.
- r0 writer: ALU r0 followed by a reader of r0.
  - Required: stall_id=0; ex_mem_regwr=0 and addr=0 throughout.
- Divide, DIV_LAT=4: DIV r3, then dependent ALU.
  - Required: ex_hold=1 and stall_id=1 for 3 cycles; MEM shows bubbles.
  - 4th cycle: stall_id=0; then ex_mem_regwraddr=3.
- Flush mid-divide: flush asserted on the 2nd hold cycle.
  - Required: next cycle EX invalid, ex_hold=0, div_cnt=0.
  - Older MEM/WB entries still drain normally.
- Reset mid-operation: rst_n=0 for one edge with all stages full.
  - Required: every output 0 the next cycle.
  - A new ID instruction is captured normally after reset.
